l1_bus_arbiter: RTL and testbench

L1_BUS_ARBITER -- requirements
Module: l1_bus_arbiter
Interface
REQ-001 SHALL have parameter PA_WIDTH, default 64, physical address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, write-through data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max consecutive D grants while I waits.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_req  input  1  L1-I read-line request, level, held until i_trans_rdy/i_bus_error.
REQ-007 SHALL have port i_pa  input  PA_WIDTH  L1-I line address.
REQ-008 SHALL have port d_req  input  4  L1-D request, [3] write_line, [2] write_through, [1] read_line, [0] read.
REQ-009 SHALL have port d_pa  input  PA_WIDTH  L1-D address.
REQ-010 SHALL have port d_size  input  4  L1-D access size.
REQ-011 SHALL have port d_wt_data  input  DATA_WIDTH  L1-D write data.
REQ-012 SHALL have port i_trans_rdy, i_bus_error, i_line_write  output  1 each  responses routed to L1-I.
REQ-013 SHALL have port d_trans_rdy, d_bus_error, d_line_write, d_entry_write  output  1 each  responses routed to L1-D.
REQ-014 SHALL have port bu_req  output  4  request to cache bus unit, same encoding as d_req.
REQ-015 SHALL have port bu_pa  output  PA_WIDTH  address to bus unit.
REQ-016 SHALL have port bu_size  output  4  size to bus unit (4'd8 for I).
REQ-017 SHALL have port bu_wt_data  output  DATA_WIDTH  write data to bus unit (zero for I).
REQ-018 SHALL have port bu_trans_rdy, bu_bus_error, bu_line_write, bu_entry_write  input  1 each  bus unit responses.
REQ-019 SHALL have port grant  output  2  one-hot owner, [1] D, [0] I, registered.
REQ-020 SHALL have port arb_abort  output  1  one-cycle pulse: owner dropped request before completion.
Function
REQ-021 SHALL implement FSM IDLE, GNT_I, GNT_D, RELEASE.
REQ-022 IDLE: d_req!=0 and (i_req==0 or starve_cnt<STARVE_LIMIT) -> GNT_D; else i_req -> GNT_I; else stay.
REQ-023 On entering GNT_D SHALL latch only highest-priority set d_req bit (write_line>write_through>read_line>read) as one-hot type.
REQ-024 On entering GNT_I SHALL latch type 4'b0010.
REQ-025 In GNT_x bu_req SHALL equal latched type; bu_pa/bu_size/bu_wt_data follow owner's live inputs combinationally; bu_req=0 in IDLE/RELEASE.
REQ-026 Latency: request sampled in IDLE at edge N, bu_req asserted in cycle N+1.
REQ-027 bu_* responses SHALL route combinationally to owner only, same cycle; non-owner response outputs 0; outside GNT_x all response outputs 0.
REQ-028 bu_trans_rdy or bu_bus_error in GNT_x -> RELEASE; RELEASE -> IDLE unconditionally (one dead cycle so masters deassert).
REQ-029 Owner request dropping to 0 in GNT_x without completion -> RELEASE, arb_abort=1 next cycle; bu_req=0 immediately.
REQ-030 starve_cnt: +1 on each GNT_D entry while i_req=1 (saturate at STARVE_LIMIT), cleared on GNT_I entry or when i_req=0 in IDLE.
REQ-031 Simultaneous completion and request drop SHALL count as completion (no arb_abort).
REQ-032 Requests changing while granted SHALL not change latched type or owner.
Reset
REQ-033 rst SHALL force state IDLE, grant=0, latched type=0, starve_cnt=0, arb_abort=0 at next edge, including mid-transaction.
REQ-034 Combinational outputs SHALL be 0 in the cycle after reset edge (IDLE).
Structure
REQ-035 Request-type encodings and FSM state encoding SHALL live in shared package l1_bus_pkg.
REQ-036 Single natural sub-module: l1_req_prio_enc (4-bit d_req to one-hot priority encode); no other hierarchy.
Verification
REQ-037 d_req=4'b0010 only, d_pa=0x1000 -> cycle+1 bu_req=4'b0010, bu_pa=0x1000, grant=2'b10; bu_trans_rdy -> d_trans_rdy same cycle, RELEASE, IDLE.
REQ-038 d_req=4'b1001 -> bu_req=4'b1000 latched; d_req changed to 4'b0001 mid-grant -> bu_req stays 4'b1000.
REQ-039 STARVE_LIMIT=2, i_req and d_req both held continuously -> grant order D, D, I, D, D, I.
REQ-040 i_req granted, i_req dropped before bu_trans_rdy -> bu_req=0 same cycle, arb_abort=1 one cycle, then IDLE.
REQ-041 rst asserted during GNT_D with bu_line_write=1 -> next cycle grant=0, bu_req=0, d_line_write=0.
REQ-042 bu_bus_error during GNT_I -> i_bus_error=1, d_bus_error=0 same cycle, no arb_abort.

---
 rtl/l1_bus_pkg.sv | 28 ++
 rtl/l1_req_prio_enc.sv | 18 +
 rtl/l1_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_l1_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_bus_pkg.sv
// Shared encodings for the L1 bus arbiter: request types, grant codes, FSM states.
package l1_bus_pkg;

  localparam int unsigned REQ_W  = 4;
  localparam int unsigned SIZE_W = 4;
  localparam int unsigned GNT_W  = 2;

  // One-hot request types, bit order matches d_req / bu_req.
  localparam logic [REQ_W-1:0] REQ_NONE          = 4'b0000;
  localparam logic [REQ_W-1:0] REQ_READ          = 4'b0001;
  localparam logic [REQ_W-1:0] REQ_READ_LINE     = 4'b0010;
  localparam logic [REQ_W-1:0] REQ_WRITE_THROUGH = 4'b0100;
  localparam logic [REQ_W-1:0] REQ_WRITE_LINE    = 4'b1000;

  localparam logic [SIZE_W-1:0] I_LINE_SIZE = 4'd8;

  localparam logic [GNT_W-1:0] GNT_NONE    = 2'b00;
  localparam logic [GNT_W-1:0] GNT_OWNER_I = 2'b01;
  localparam logic [GNT_W-1:0] GNT_OWNER_D = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_I   = 2'd1,
    ST_GNT_D   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/l1_req_prio_enc.sv
// Reduces a multi-bit L1-D request to its single highest-priority type:
// write_line > write_through > read_line > read.
module l1_req_prio_enc
  import l1_bus_pkg::*;
(
  input  logic [REQ_W-1:0] req,
  output logic [REQ_W-1:0] type_c
);

  always_comb begin
    type_c = REQ_NONE;
    if (req[3])      type_c = REQ_WRITE_LINE;
    else if (req[2]) type_c = REQ_WRITE_THROUGH;
    else if (req[1]) type_c = REQ_READ_LINE;
    else if (req[0]) type_c = REQ_READ;
  end

endmodule

// File: rtl/l1_bus_arbiter.sv
// Arbitrates the L1-I and L1-D caches onto a single cache bus unit port.
// D wins ties until I has waited STARVE_LIMIT consecutive D grants.
module l1_bus_arbiter
  import l1_bus_pkg::*;
#(
  parameter int unsigned PA_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [PA_WIDTH-1:0]   i_pa,
  input  logic [REQ_W-1:0]      d_req,
  input  logic [PA_WIDTH-1:0]   d_pa,
  input  logic [SIZE_W-1:0]     d_size,
  input  logic [DATA_WIDTH-1:0] d_wt_data,
  output logic                  i_trans_rdy,
  output logic                  i_bus_error,
  output logic                  i_line_write,
  output logic                  d_trans_rdy,
  output logic                  d_bus_error,
  output logic                  d_line_write,
  output logic                  d_entry_write,
  output logic [REQ_W-1:0]      bu_req,
  output logic [PA_WIDTH-1:0]   bu_pa,
  output logic [SIZE_W-1:0]     bu_size,
  output logic [DATA_WIDTH-1:0] bu_wt_data,
  input  logic                  bu_trans_rdy,
  input  logic                  bu_bus_error,
  input  logic                  bu_line_write,
  input  logic                  bu_entry_write,
  output logic [GNT_W-1:0]      grant,
  output logic                  arb_abort
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state, state_nxt;
  logic [GNT_W-1:0] grant_nxt;
  logic [REQ_W-1:0] req_type, req_type_nxt, d_type_c;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             arb_abort_nxt;
  logic             done_c;

  l1_req_prio_enc u_prio_enc (
    .req    (d_req),
    .type_c (d_type_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= GNT_NONE;
      req_type   <= REQ_NONE;
      starve_cnt <= '0;
      arb_abort  <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      req_type   <= req_type_nxt;
      starve_cnt <= starve_cnt_nxt;
      arb_abort  <= arb_abort_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    req_type_nxt   = req_type;
    starve_cnt_nxt = starve_cnt;
    arb_abort_nxt  = 1'b0;
    done_c         = bu_trans_rdy | bu_bus_error;
    bu_req         = REQ_NONE;
    bu_pa          = '0;
    bu_size        = '0;
    bu_wt_data     = '0;
    i_trans_rdy    = 1'b0;
    i_bus_error    = 1'b0;
    i_line_write   = 1'b0;
    d_trans_rdy    = 1'b0;
    d_bus_error    = 1'b0;
    d_line_write   = 1'b0;
    d_entry_write  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!i_req) starve_cnt_nxt = '0;
        if ((d_req != REQ_NONE) && (!i_req || (starve_cnt < STARVE_MAX))) begin
          state_nxt    = ST_GNT_D;
          grant_nxt    = GNT_OWNER_D;
          req_type_nxt = d_type_c;
          if (i_req && (starve_cnt < STARVE_MAX)) starve_cnt_nxt = CNT_W'(starve_cnt + 1'b1);
        end else if (i_req) begin
          state_nxt      = ST_GNT_I;
          grant_nxt      = GNT_OWNER_I;
          req_type_nxt   = REQ_READ_LINE;
          starve_cnt_nxt = '0;
        end
      end

      ST_GNT_I: begin
        bu_req       = i_req ? req_type : REQ_NONE;
        bu_pa        = i_pa;
        bu_size      = I_LINE_SIZE;
        i_trans_rdy  = bu_trans_rdy;
        i_bus_error  = bu_bus_error;
        i_line_write = bu_line_write;
        // Completion takes precedence over a same-cycle request drop.
        if (done_c || !i_req) begin
          state_nxt     = ST_RELEASE;
          grant_nxt     = GNT_NONE;
          req_type_nxt  = REQ_NONE;
          arb_abort_nxt = !done_c;
        end
      end

      ST_GNT_D: begin
        bu_req        = (d_req != REQ_NONE) ? req_type : REQ_NONE;
        bu_pa         = d_pa;
        bu_size       = d_size;
        bu_wt_data    = d_wt_data;
        d_trans_rdy   = bu_trans_rdy;
        d_bus_error   = bu_bus_error;
        d_line_write  = bu_line_write;
        d_entry_write = bu_entry_write;
        if (done_c || (d_req == REQ_NONE)) begin
          state_nxt     = ST_RELEASE;
          grant_nxt     = GNT_NONE;
          req_type_nxt  = REQ_NONE;
          arb_abort_nxt = !done_c;
        end
      end

      ST_RELEASE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Scoreboarded bench for l1_bus_arbiter: expected grants are queued at stimulus time
// and checked by a monitor on the first cycle of every new grant.
module tb_l1_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [63:0] i_pa;
  logic [3:0]  d_req;
  logic [63:0] d_pa;
  logic [3:0]  d_size;
  logic [63:0] d_wt_data;
  logic        i_trans_rdy, i_bus_error, i_line_write;
  logic        d_trans_rdy, d_bus_error, d_line_write, d_entry_write;
  logic [3:0]  bu_req;
  logic [63:0] bu_pa;
  logic [3:0]  bu_size;
  logic [63:0] bu_wt_data;
  logic        bu_trans_rdy, bu_bus_error, bu_line_write, bu_entry_write;
  logic [1:0]  grant;
  logic        arb_abort;

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  gnt;
    logic [63:0] pa;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [1:0] prev_grant = 2'b00;
  int         n_cmp = 0;
  int         n_err = 0;
  int         got;

  always #5 clk = ~clk;

  l1_bus_arbiter #(
    .PA_WIDTH     (64),
    .DATA_WIDTH   (64),
    .STARVE_LIMIT (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_pa           (i_pa),
    .d_req          (d_req),
    .d_pa           (d_pa),
    .d_size         (d_size),
    .d_wt_data      (d_wt_data),
    .i_trans_rdy    (i_trans_rdy),
    .i_bus_error    (i_bus_error),
    .i_line_write   (i_line_write),
    .d_trans_rdy    (d_trans_rdy),
    .d_bus_error    (d_bus_error),
    .d_line_write   (d_line_write),
    .d_entry_write  (d_entry_write),
    .bu_req         (bu_req),
    .bu_pa          (bu_pa),
    .bu_size        (bu_size),
    .bu_wt_data     (bu_wt_data),
    .bu_trans_rdy   (bu_trans_rdy),
    .bu_bus_error   (bu_bus_error),
    .bu_line_write  (bu_line_write),
    .bu_entry_write (bu_entry_write),
    .grant          (grant),
    .arb_abort      (arb_abort)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] req, input logic [1:0] gnt, input logic [63:0] pa);
    exp_t e;
    e.req = req;
    e.gnt = gnt;
    e.pa  = pa;
    sb.push_back(e);
  endtask

  // Check each fresh grant against the oldest queued expectation.
  always @(negedge clk) begin
    if (prev_grant == 2'b00 && grant != 2'b00) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_grant", 64'(grant), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_grant", 64'(grant), 64'(mon_e.gnt));
        check("sb_bu_req", 64'(bu_req), 64'(mon_e.req));
        check("sb_bu_pa", bu_pa, mon_e.pa);
      end
    end
    prev_grant = grant;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; i_pa = '0; d_req = '0; d_pa = '0; d_size = '0; d_wt_data = '0;
    bu_trans_rdy = 1'b0; bu_bus_error = 1'b0; bu_line_write = 1'b0; bu_entry_write = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    settle();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_bu_req", 64'(bu_req), 64'd0);
    check("rst_abort", 64'(arb_abort), 64'd0);
    check("rst_d_trans_rdy", 64'(d_trans_rdy), 64'd0);

    // Single D read_line, one-cycle latency, completion routed to D only.
    step();
    d_req = 4'b0010; d_pa = 64'h1000; d_size = 4'd8; d_wt_data = 64'hDEAD_BEEF;
    push_exp(4'b0010, 2'b10, 64'h1000);
    settle();
    check("t1_latency_bu_req", 64'(bu_req), 64'd0);
    step();
    settle();
    check("t1_bu_wt_data", bu_wt_data, 64'hDEAD_BEEF);
    check("t1_bu_size", 64'(bu_size), 64'd8);
    bu_trans_rdy = 1'b1;
    #1;
    check("t1_d_trans_rdy", 64'(d_trans_rdy), 64'd1);
    check("t1_i_trans_rdy", 64'(i_trans_rdy), 64'd0);
    step();
    bu_trans_rdy = 1'b0; d_req = 4'b0000;
    settle();
    check("t1_release_grant", 64'(grant), 64'd0);
    check("t1_release_bu_req", 64'(bu_req), 64'd0);
    check("t1_no_abort", 64'(arb_abort), 64'd0);
    step();

    // Priority latch, type held while d_req changes, completion with simultaneous drop.
    d_req = 4'b1001; d_pa = 64'h2000;
    push_exp(4'b1000, 2'b10, 64'h2000);
    step();
    d_req = 4'b0001;
    settle();
    check("t2_hold_bu_req", 64'(bu_req), 64'b1000);
    check("t2_hold_grant", 64'(grant), 64'b10);
    step();
    d_req = 4'b0000; bu_trans_rdy = 1'b1;
    settle();
    check("t2_drop_bu_req", 64'(bu_req), 64'd0);
    check("t2_drop_trans_rdy", 64'(d_trans_rdy), 64'd1);
    step();
    bu_trans_rdy = 1'b0;
    settle();
    check("t2_done_wins_no_abort", 64'(arb_abort), 64'd0);
    step();

    // Starvation: both held, STARVE_LIMIT=2 gives D, D, I, D, D, I.
    i_req = 1'b1; i_pa = 64'h3000; d_req = 4'b0001; d_pa = 64'h4000; d_size = 4'd2;
    for (int g = 0; g < 6; g++) begin
      if (g % 3 == 2) push_exp(4'b0010, 2'b01, 64'h3000);
      else            push_exp(4'b0001, 2'b10, 64'h4000);
    end
    for (int g = 0; g < 6; g++) begin
      got = 0;
      for (int k = 0; k < 10 && got == 0; k++) begin
        step();
        settle();
        if (grant != 2'b00) got = 1;
      end
      check("t3_grant_seen", 64'(got), 64'd1);
      if (grant == 2'b01) begin
        check("t3_i_bu_size", 64'(bu_size), 64'd8);
        check("t3_i_bu_wt_data", bu_wt_data, 64'd0);
      end
      bu_trans_rdy = 1'b1;
      step();
      bu_trans_rdy = 1'b0;
    end
    i_req = 1'b0; d_req = 4'b0000;
    step();

    // I owner drops request before completion -> abort pulse.
    i_req = 1'b1; i_pa = 64'h5000;
    push_exp(4'b0010, 2'b01, 64'h5000);
    step();
    settle();
    i_req = 1'b0;
    #1;
    check("t4_drop_bu_req", 64'(bu_req), 64'd0);
    step();
    settle();
    check("t4_abort_pulse", 64'(arb_abort), 64'd1);
    check("t4_abort_grant", 64'(grant), 64'd0);
    step();
    settle();
    check("t4_abort_cleared", 64'(arb_abort), 64'd0);

    // Bus error during I grant goes only to I.
    step();
    i_req = 1'b1; i_pa = 64'h6000;
    push_exp(4'b0010, 2'b01, 64'h6000);
    step();
    settle();
    bu_bus_error = 1'b1;
    #1;
    check("t5_i_bus_error", 64'(i_bus_error), 64'd1);
    check("t5_d_bus_error", 64'(d_bus_error), 64'd0);
    step();
    bu_bus_error = 1'b0; i_req = 1'b0;
    settle();
    check("t5_no_abort", 64'(arb_abort), 64'd0);
    step();

    // Reset mid D transaction with a line write in flight.
    d_req = 4'b1000; d_pa = 64'h7000;
    push_exp(4'b1000, 2'b10, 64'h7000);
    step();
    settle();
    bu_line_write = 1'b1;
    #1;
    check("t6_d_line_write", 64'(d_line_write), 64'd1);
    rst = 1'b1;
    step();
    settle();
    check("t6_rst_grant", 64'(grant), 64'd0);
    check("t6_rst_bu_req", 64'(bu_req), 64'd0);
    check("t6_rst_d_line_write", 64'(d_line_write), 64'd0);
    rst = 1'b0; d_req = 4'b0000; bu_line_write = 1'b0;
    step();
    step();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
